spram_stream_ctrl: RTL

//  Front-end controller directly upstream of the byte-enable single-port RAM (singleport_ram_be).

---
 rtl/spram_ctrl_pkg.sv | 9 +
 rtl/spram_rsp_fifo.sv | 43 ++++
 rtl/spram_stream_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/spram_ctrl_pkg.sv
// Shared types for the single-port RAM stream controller.
// Optional power-up clear is enabled with SPRAM_STREAM_CTRL_INIT_CLEAR_EN.
package spram_ctrl_pkg;
  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_t;

  localparam int BE_MAX = 64;
  localparam logic [BE_MAX-1:0] BE_ALL_ONES = '1;
endpackage

// File: rtl/spram_rsp_fifo.sv
// Response FIFO, first-word fall-through; dout is the head entry whenever count != 0.
module spram_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_s_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= f_inc(r_wp);
      if (i_pop)  r_rp <= f_inc(r_rp);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

// File: rtl/spram_stream_ctrl.sv
// Arbitrates write/read request streams onto one single-port RAM and returns read data in order.
// Define SPRAM_STREAM_CTRL_INIT_CLEAR_EN to zero the whole RAM after every reset.
module spram_stream_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int WORDS      = 256,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BE     = 1,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_s_rst,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [NUM_BE-1:0]     i_wr_be,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic                  o_ram_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [WIDTH-1:0]      o_ram_data_in,
  output logic [NUM_BE-1:0]     o_ram_we,
  output logic [NUM_BE-1:0]     o_ram_re,
  input  logic [WIDTH-1:0]      i_ram_data_out
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [NUM_BE-1:0] BE_ONES = BE_ALL_ONES[NUM_BE-1:0];

  state_t                r_state, w_state_nxt;
  grant_t                r_last_gnt, w_gnt;
  logic                  r_outstanding;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CW-1:0]         w_fifo_cnt;
  logic [WIDTH-1:0]      w_fifo_dout;
  logic                  w_run, w_rd_can, w_wr_req, w_rd_req;
  logic                  w_fifo_empty, w_push, w_pop;

  assign w_run    = !i_s_rst && (r_state == RUN);
  // Credits cover both buffered entries and the read still in the RAM pipe.
  assign w_rd_can = w_run && (({1'b0, w_fifo_cnt} + (CW+1)'(r_outstanding)) < (CW+1)'(RSP_DEPTH));
  assign w_wr_req = i_wr_valid && w_run;
  assign w_rd_req = i_rd_valid && w_rd_can;

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_wr_req && w_rd_req) w_gnt = (r_last_gnt == GNT_RD) ? GNT_WR : GNT_RD;
    else if (w_wr_req)        w_gnt = GNT_WR;
    else if (w_rd_req)        w_gnt = GNT_RD;
  end

  assign o_wr_ready = w_run && (w_gnt != GNT_RD);
  assign o_rd_ready = w_rd_can && (w_gnt != GNT_WR);
  assign o_ram_en   = 1'b1;

`ifdef SPRAM_STREAM_CTRL_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  w_clearing;
  assign w_clearing = !i_s_rst && (r_state == CLEAR);

  always_ff @(posedge i_clk) begin
    if (i_s_rst)                 r_clr_addr <= '0;
    else if (r_state == CLEAR)   r_clr_addr <= r_clr_addr + 1'b1;
  end
`endif

  always_comb begin
    o_ram_addr    = r_addr;
    o_ram_data_in = i_wr_data;
    o_ram_we      = '0;
    o_ram_re      = '0;
`ifdef SPRAM_STREAM_CTRL_INIT_CLEAR_EN
    if (w_clearing) begin
      o_ram_addr    = r_clr_addr;
      o_ram_data_in = '0;
      o_ram_we      = BE_ONES;
    end
`endif
    case (w_gnt)
      GNT_WR: begin
        o_ram_we   = i_wr_be;
        o_ram_addr = i_wr_addr;
      end
      GNT_RD: begin
        o_ram_re   = BE_ONES;
        o_ram_addr = i_rd_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
`ifdef SPRAM_STREAM_CTRL_INIT_CLEAR_EN
    if (r_state == CLEAR && r_clr_addr == ADDR_WIDTH'(WORDS - 1)) w_state_nxt = RUN;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
`ifdef SPRAM_STREAM_CTRL_INIT_CLEAR_EN
      r_state <= CLEAR;
`else
      r_state <= RUN;
`endif
      r_last_gnt    <= GNT_RD;
      r_outstanding <= 1'b0;
      r_addr        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= (w_gnt == GNT_RD);
      r_addr        <= o_ram_addr;
      if (w_gnt != GNT_NONE) r_last_gnt <= w_gnt;
    end
  end

  // Empty FIFO: RAM data goes straight out, and is only buffered if not taken this cycle.
  assign w_fifo_empty = (w_fifo_cnt == '0);
  assign o_rsp_valid  = !i_s_rst && (!w_fifo_empty || r_outstanding);
  assign o_rsp_data   = w_fifo_empty ? i_ram_data_out : w_fifo_dout;
  assign w_pop        = !i_s_rst && i_rsp_ready && !w_fifo_empty;
  assign w_push       = r_outstanding && !(w_fifo_empty && i_rsp_ready);

  spram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_s_rst (i_s_rst),
    .i_push  (w_push),
    .i_din   (i_ram_data_out),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_cnt)
  );
endmodule
